// File: rtl/c17_pipe.sv
// rtl/c17_pipe.sv - two-stage pipelined array of NAND2 c17 channels with optional toggle counters
// Optional feature macro: C17_PIPE_TOGGLE_CNT_EN enables the per-channel output toggle counters.
module c17_pipe #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS-1:0]       nx1,
    input  logic [CHANNELS-1:0]       nx2,
    input  logic [CHANNELS-1:0]       nx3,
    input  logic [CHANNELS-1:0]       nx6,
    input  logic [CHANNELS-1:0]       nx7,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       nx22,
    output logic [CHANNELS-1:0]       nx23,
    input  logic                      cnt_clr,
    output logic [CHANNELS*CNT_W-1:0] tog22,
    output logic [CHANNELS*CNT_W-1:0] tog23
);

    function automatic logic [CHANNELS-1:0] nand2(input logic [CHANNELS-1:0] a,
                                                  input logic [CHANNELS-1:0] b);
        return ~(a & b);
    endfunction

    logic [CHANNELS-1:0] s1_x1, s1_x2, s1_x3, s1_x6, s1_x7;
    logic                v1, v2;
    logic [CHANNELS-1:0] q22, q23;
    logic [CHANNELS-1:0] n0, n1, n2, n3, c22, c23;
    logic                take1, adv2, out_fire;

    always_comb begin
        n1  = nand2(s1_x3, s1_x6);
        n0  = nand2(s1_x1, s1_x3);
        n3  = nand2(s1_x2, n1);
        n2  = nand2(s1_x7, n1);
        c22 = nand2(n0, n3);
        c23 = nand2(n3, n2);
    end

    // Stage 1 may refill whenever it is empty or draining into stage 2 this cycle.
    assign adv2      = v1 && (!v2 || out_ready);
    assign in_ready  = !rst && (!v1 || !v2 || out_ready);
    assign take1     = in_valid && in_ready;
    assign out_fire  = v2 && out_ready;
    assign out_valid = v2;
    assign nx22      = q22;
    assign nx23      = q23;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            q22   <= '0;
            q23   <= '0;
            s1_x1 <= '0;
            s1_x2 <= '0;
            s1_x3 <= '0;
            s1_x6 <= '0;
            s1_x7 <= '0;
        end else begin
            if (take1) begin
                v1    <= 1'b1;
                s1_x1 <= nx1;
                s1_x2 <= nx2;
                s1_x3 <= nx3;
                s1_x6 <= nx6;
                s1_x7 <= nx7;
            end else if (adv2) begin
                v1 <= 1'b0;
            end
            if (adv2) begin
                v2  <= 1'b1;
                q22 <= c22;
                q23 <= c23;
            end else if (out_fire) begin
                v2 <= 1'b0;
            end
        end
    end

`ifdef C17_PIPE_TOGGLE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CHANNELS-1:0]       prev22, prev23;
    logic [CHANNELS*CNT_W-1:0] cnt22, cnt23;

    // History tracks the last transferred bits and survives cnt_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev22 <= '0;
            prev23 <= '0;
            cnt22  <= '0;
            cnt23  <= '0;
        end else begin
            if (out_fire) begin
                prev22 <= q22;
                prev23 <= q23;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (cnt_clr) begin
                    cnt22[k*CNT_W +: CNT_W] <= '0;
                    cnt23[k*CNT_W +: CNT_W] <= '0;
                end else if (out_fire) begin
                    if ((q22[k] != prev22[k]) && (cnt22[k*CNT_W +: CNT_W] != CNT_MAX))
                        cnt22[k*CNT_W +: CNT_W] <= cnt22[k*CNT_W +: CNT_W] + CNT_ONE;
                    if ((q23[k] != prev23[k]) && (cnt23[k*CNT_W +: CNT_W] != CNT_MAX))
                        cnt23[k*CNT_W +: CNT_W] <= cnt23[k*CNT_W +: CNT_W] + CNT_ONE;
                end
            end
        end
    end

    assign tog22 = cnt22;
    assign tog23 = cnt23;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign tog22 = '0;
    assign tog23 = '0;
`endif

endmodule

// File: doc/c17_pipe.md
C17_PIPE -- requirements
Module: c17_pipe

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent c17 channels (legal 1..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each toggle counter (legal 2..16).
REQ-003 clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the input vector set is valid this cycle.
REQ-006 in_ready  output  1  the block accepts the input vector set this cycle.
REQ-007 nx1, nx2, nx3, nx6, nx7  input  CHANNELS each  per-channel c17 primary inputs; bit k belongs to channel k.
REQ-008 out_valid  output  1  nx22 and nx23 hold a valid result.
REQ-009 out_ready  input  1  downstream consumes the result this cycle.
REQ-010 nx22, nx23  output  CHANNELS each  per-channel c17 primary outputs.
REQ-011 cnt_clr  input  1  synchronous clear of all toggle counters.
REQ-012 tog22, tog23  output  CHANNELS*CNT_W each  per-channel toggle counters; channel k occupies bits [k*CNT_W +: CNT_W].

Function
REQ-013 Per channel, n1=NAND(nx3,nx6), n0=NAND(nx1,nx3), n3=NAND(nx2,n1), n2=NAND(nx7,n1), nx22=NAND(n0,n3), nx23=NAND(n3,n2); the logic SHALL be built only from NAND2 functions.
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 Stage 1 SHALL register the raw inputs on an input transfer; stage 2 SHALL register the c17 results of stage 1.
REQ-016 Latency SHALL be 2 cycles: out_valid rises on the 2nd rising edge after the input-transfer edge, provided stage 2 is free.
REQ-017 in_ready SHALL equal !rst && (!v1 || !v2 || out_ready), where v1 and v2 are the stage valid flags; bubbles SHALL collapse.
REQ-018 Throughput SHALL be one transfer per cycle while out_ready is held at 1.
REQ-019 While out_valid=1 and out_ready=0, nx22, nx23 and out_valid SHALL hold stable.
REQ-020 A simultaneous output transfer and stage-1-to-stage-2 advance SHALL lose no data and duplicate no data.
REQ-021 On each output transfer, a channel's counter SHALL increment if the transferred bit differs from that channel's previously transferred bit; the first comparison after reset SHALL be against 0.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-023 cnt_clr=1 SHALL zero all counters on the next edge and SHALL win over a coincident increment; cnt_clr SHALL NOT clear the previous-value history or pipeline data.

Reset
REQ-024 While rst=1: in_ready=0; on the edge, v1, v2 and out_valid SHALL go to 0, nx22 and nx23 to 0, and counters and history to 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight data; no output transfer SHALL follow for data accepted before reset.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro C17_PIPE_TOGGLE_CNT_EN defined: counters and history registers per REQ-021..023 SHALL be present.
REQ-028 Macro C17_PIPE_TOGGLE_CNT_EN undefined: tog22 and tog23 SHALL be constant 0, cnt_clr SHALL be ignored, no counter flops SHALL exist, and pipeline behaviour SHALL be unchanged.

Verification
REQ-029 CHANNELS=4, channel 0 {nx1,nx2,nx3,nx6,nx7}=1,0,1,0,0, out_ready=1 -> 2 cycles later nx22[0]=1, nx23[0]=0, out_valid=1.
REQ-030 Channel 0 all-zero inputs -> nx22[0]=0, nx23[0]=0; channel 0 nx2=nx3=1, others 0 -> nx22[0]=1, nx23[0]=1.
REQ-031 Backpressure: 5 back-to-back vectors, out_ready=0 for cycles 3..6 -> in_ready=0 while both stages are full, outputs stable, all 5 results delivered in order with none lost.
REQ-032 Toggle count (macro on, CNT_W=2): alternate channel-0 nx22 results 1,0,1,0,1 -> tog22[1:0] saturates at 3; cnt_clr asserted on a transfer cycle -> 0.
REQ-033 Reset mid-stream: rst pulsed with both stages valid -> out_valid=0 next cycle, counters=0, in_ready=1 the cycle after rst drops.
REQ-034 Macro off: repeat REQ-032 -> tog22 and tog23 stay 0 and the data path results match REQ-029.
